// File: rtl/bus_pkg.sv
// Shared definitions for the master/responder register bus: widths, base
// address and the responder state encoding.
package bus_pkg;

   localparam int          BUS_ADDR_W    = 16;
   localparam int          BUS_DATA_W    = 32;
   localparam logic [15:0] BUS_BASE_ADDR = 16'h0010;

   // RSP_ prefix keeps these distinct from the master's own state names.
   typedef enum logic [1:0] {
      RSP_IDLE,
      RSP_ADDR,
      RSP_DATA,
      RSP_DONE
   } rsp_state_t;

endpackage

// File: rtl/slave_reg_if.sv
// Register bus signal bundle; the master drives the request, the responder
// returns ready/read_data/error.
interface slave_reg_if
   import bus_pkg::*;
#(
   parameter int ADDR_W = BUS_ADDR_W,
   parameter int DATA_W = BUS_DATA_W
);

   logic              valid;
   logic              read;
   logic              write;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] write_data;
   logic              ready;
   logic [DATA_W-1:0] read_data;
   logic              error;

   modport master (
      output valid, read, write, addr, write_data,
      input  ready, read_data, error
   );

   modport slave (
      input  valid, read, write, addr, write_data,
      output ready, read_data, error
   );

endinterface

// File: rtl/slave_regfile.sv
// NUM_REGS x DATA_W register storage: synchronous write port, combinational
// read port, asynchronous active-low clear.
module slave_regfile
   import bus_pkg::*;
#(
   parameter int DATA_W   = BUS_DATA_W,
   parameter int NUM_REGS = 16,
   parameter int IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              wr_en,
   input  logic [IDX_W-1:0]  wr_idx,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [IDX_W-1:0]  rd_idx,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] regs_q [NUM_REGS];
   logic [DATA_W-1:0] regs_d [NUM_REGS];

   always_comb begin
      regs_d = regs_q;
      if (wr_en && (int'(wr_idx) < NUM_REGS)) begin
         regs_d[wr_idx] = wr_data;
      end
   end

   always_comb begin
      rd_data = '0;
      if (int'(rd_idx) < NUM_REGS) begin
         rd_data = regs_q[rd_idx];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         regs_q <= regs_d;
      end
   end

endmodule

// File: rtl/slave_reg.sv
// Register bus responder: latches a request, waits WAIT_CYCLES, decodes it
// onto the register file and returns a registered one-cycle ready.
module slave_reg
   import bus_pkg::*;
#(
   parameter int                ADDR_W      = BUS_ADDR_W,
   parameter int                DATA_W      = BUS_DATA_W,
   parameter int                NUM_REGS    = 16,
   parameter logic [ADDR_W-1:0] BASE_ADDR   = ADDR_W'(BUS_BASE_ADDR),
   parameter int                WAIT_CYCLES = 1
) (
   input  logic       clk,
   input  logic       reset_n,
   slave_reg_if.slave bus
);

   localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [ADDR_W:0] SPAN = (ADDR_W+1)'(4 * NUM_REGS);

   rsp_state_t        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              read_q, read_d;
   logic              write_q, write_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              ready_q, ready_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              error_q, error_d;

   logic [ADDR_W-1:0] offset;
   logic              hit;
   logic [IDX_W-1:0]  idx;
   logic              wr_en;
   logic [DATA_W-1:0] rf_rdata;

   // Range check on the offset is equivalent to addr < BASE+4*NUM_REGS once addr >= BASE.
   always_comb begin
      offset = addr_q - BASE_ADDR;
      idx    = offset[IDX_W+1:2];
      hit    = (addr_q >= BASE_ADDR) &&
               ({1'b0, offset} < SPAN) &&
               (addr_q[1:0] == 2'b00) &&
               (read_q ^ write_q);
      wr_en  = (state_q == RSP_DATA) && hit && write_q;
   end

   slave_regfile #(
      .DATA_W   (DATA_W),
      .NUM_REGS (NUM_REGS),
      .IDX_W    (IDX_W)
   ) u_regfile (
      .clk     (clk),
      .reset_n (reset_n),
      .wr_en   (wr_en),
      .wr_idx  (idx),
      .wr_data (wdata_q),
      .rd_idx  (idx),
      .rd_data (rf_rdata)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      read_d  = read_q;
      write_d = write_q;
      wdata_d = wdata_q;
      ready_d = 1'b0;
      rdata_d = '0;
      error_d = 1'b0;
      case (state_q)
         RSP_IDLE: begin
            if (bus.valid) begin
               addr_d  = bus.addr;
               read_d  = bus.read;
               write_d = bus.write;
               wdata_d = bus.write_data;
               cnt_d   = CNT_W'(WAIT_CYCLES - 1);
               state_d = RSP_ADDR;
            end
         end
         RSP_ADDR: begin
            if (!bus.valid) begin
               state_d = RSP_IDLE;
            end else if (cnt_q == '0) begin
               state_d = RSP_DATA;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         RSP_DATA: begin
            ready_d = 1'b1;
            error_d = !hit;
            if (hit && read_q) begin
               rdata_d = rf_rdata;
            end
            state_d = RSP_DONE;
         end
         RSP_DONE: begin
            if (!bus.valid) begin
               state_d = RSP_IDLE;
            end
         end
         default: state_d = RSP_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= RSP_IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         read_q  <= 1'b0;
         write_q <= 1'b0;
         wdata_q <= '0;
         ready_q <= 1'b0;
         rdata_q <= '0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         read_q  <= read_d;
         write_q <= write_d;
         wdata_q <= wdata_d;
         ready_q <= ready_d;
         rdata_q <= rdata_d;
         error_q <= error_d;
      end
   end

   assign bus.ready     = ready_q;
   assign bus.read_data = rdata_q;
   assign bus.error     = error_q;

endmodule

// File: tb/tb_slave_reg.sv
// Directed bench for slave_reg: one responder with WAIT_CYCLES=1 and one with
// WAIT_CYCLES=3, sharing stimulus and selected by sel.
module tb_slave_reg;

   logic        clk = 1'b0;
   logic        t_reset_n = 1'b0;
   logic        sel = 1'b0;
   logic        t_valid = 1'b0;
   logic        t_read = 1'b0;
   logic        t_write = 1'b0;
   logic [15:0] t_addr = '0;
   logic [31:0] t_wdata = '0;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   slave_reg_if #(.ADDR_W(16), .DATA_W(32)) bus1 ();
   slave_reg_if #(.ADDR_W(16), .DATA_W(32)) bus3 ();

   assign bus1.valid      = t_valid & ~sel;
   assign bus1.read       = t_read;
   assign bus1.write      = t_write;
   assign bus1.addr       = t_addr;
   assign bus1.write_data = t_wdata;
   assign bus3.valid      = t_valid & sel;
   assign bus3.read       = t_read;
   assign bus3.write      = t_write;
   assign bus3.addr       = t_addr;
   assign bus3.write_data = t_wdata;

   logic        cur_ready;
   logic [31:0] cur_rdata;
   logic        cur_error;
   assign cur_ready = sel ? bus3.ready     : bus1.ready;
   assign cur_rdata = sel ? bus3.read_data : bus1.read_data;
   assign cur_error = sel ? bus3.error     : bus1.error;

   slave_reg #(.WAIT_CYCLES(1)) dut1 (
      .clk     (clk),
      .reset_n (t_reset_n),
      .bus     (bus1)
   );

   slave_reg #(.WAIT_CYCLES(3)) dut3 (
      .clk     (clk),
      .reset_n (t_reset_n),
      .bus     (bus3)
   );

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
   endtask

   // Full transfer; lat counts edges from the request-sampling edge to ready.
   task automatic apply_stimulus(input logic s, input logic rd, input logic wr,
                                 input logic [15:0] a, input logic [31:0] wd,
                                 input int hold, output int lat,
                                 output logic [31:0] rdat, output logic err,
                                 output int pulses);
      sel = s;
      @(negedge clk);
      t_valid = 1'b1; t_read = rd; t_write = wr; t_addr = a; t_wdata = wd;
      @(posedge clk);
      lat = 0; rdat = 'x; err = 1'bx; pulses = 0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         if (cur_ready) begin
            lat = i; rdat = cur_rdata; err = cur_error; pulses = 1;
            break;
         end
      end
      repeat (hold) begin
         @(posedge clk); #1;
         if (cur_ready) pulses++;
      end
      @(negedge clk);
      t_valid = 1'b0; t_read = 1'b0; t_write = 1'b0;
      @(posedge clk); #1;
      if (cur_ready) pulses++;
   endtask

   int          lat;
   int          pulses;
   int          seen;
   logic [31:0] rdat;
   logic        err;

   initial begin
      #1;
      check_output("rst_ready", 32'(bus1.ready), 32'd0);
      check_output("rst_rdata", bus1.read_data, 32'd0);
      check_output("rst_error", 32'(bus1.error), 32'd0);
      repeat (2) @(negedge clk);
      t_reset_n = 1'b1;

      apply_stimulus(1'b0, 1'b0, 1'b1, 16'h0010, 32'hDEADBEEF, 0, lat, rdat, err, pulses);
      check_output("wr10_lat", 32'(lat), 32'd2);
      check_output("wr10_err", 32'(err), 32'd0);
      apply_stimulus(1'b0, 1'b1, 1'b0, 16'h0010, 32'h0, 0, lat, rdat, err, pulses);
      check_output("rd10_data", rdat, 32'hDEADBEEF);
      check_output("rd10_err", 32'(err), 32'd0);

      apply_stimulus(1'b0, 1'b1, 1'b0, 16'h0100, 32'h0, 0, lat, rdat, err, pulses);
      check_output("rd100_err", 32'(err), 32'd1);
      check_output("rd100_data", rdat, 32'd0);
      apply_stimulus(1'b0, 1'b1, 1'b0, 16'h0012, 32'h0, 0, lat, rdat, err, pulses);
      check_output("rd12_err", 32'(err), 32'd1);
      check_output("rd12_data", rdat, 32'd0);
      apply_stimulus(1'b0, 1'b1, 1'b0, 16'h0010, 32'h0, 0, lat, rdat, err, pulses);
      check_output("rd10_again", rdat, 32'hDEADBEEF);

      apply_stimulus(1'b0, 1'b1, 1'b1, 16'h0014, 32'h55AA55AA, 0, lat, rdat, err, pulses);
      check_output("rw14_err", 32'(err), 32'd1);
      apply_stimulus(1'b0, 1'b1, 1'b0, 16'h0014, 32'h0, 0, lat, rdat, err, pulses);
      check_output("rd14_data", rdat, 32'd0);

      // Abort on the WAIT_CYCLES=3 responder while it is still counting.
      sel = 1'b1;
      @(negedge clk);
      t_valid = 1'b1; t_write = 1'b1; t_addr = 16'h0018; t_wdata = 32'h12345678;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      t_valid = 1'b0; t_write = 1'b0;
      seen = 0;
      repeat (8) begin
         @(posedge clk); #1;
         if (bus3.ready) seen++;
      end
      check_output("abort_ready", 32'(seen), 32'd0);
      apply_stimulus(1'b1, 1'b1, 1'b0, 16'h0018, 32'h0, 0, lat, rdat, err, pulses);
      check_output("w3_rd18_data", rdat, 32'd0);
      check_output("w3_rd18_lat", 32'(lat), 32'd4);

      // Reset asserted while ready is high on a read of DEADBEEF.
      sel = 1'b0;
      @(negedge clk);
      t_valid = 1'b1; t_read = 1'b1; t_addr = 16'h0010;
      @(posedge clk);
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (bus1.ready) break;
      end
      check_output("pre_rst_data", bus1.read_data, 32'hDEADBEEF);
      #1 t_reset_n = 1'b0;
      #1;
      check_output("rst_at_rdy_ready", 32'(bus1.ready), 32'd0);
      check_output("rst_at_rdy_rdata", bus1.read_data, 32'd0);
      t_valid = 1'b0; t_read = 1'b0;
      @(negedge clk);
      t_reset_n = 1'b1;

      // Reset in the cycle before the write edge; the write must be lost.
      @(negedge clk);
      t_valid = 1'b1; t_write = 1'b1; t_addr = 16'h001C; t_wdata = 32'hAAAA5555;
      @(posedge clk);
      @(posedge clk);
      #2 t_reset_n = 1'b0;
      #1;
      check_output("rst_mid_ready", 32'(bus1.ready), 32'd0);
      t_valid = 1'b0; t_write = 1'b0;
      @(negedge clk);
      t_reset_n = 1'b1;
      apply_stimulus(1'b0, 1'b1, 1'b0, 16'h001C, 32'h0, 0, lat, rdat, err, pulses);
      check_output("post_rst_rd1c", rdat, 32'd0);
      apply_stimulus(1'b0, 1'b1, 1'b0, 16'h0010, 32'h0, 0, lat, rdat, err, pulses);
      check_output("post_rst_rd10", rdat, 32'd0);

      apply_stimulus(1'b0, 1'b0, 1'b1, 16'h0024, 32'h11112222, 5, lat, rdat, err, pulses);
      check_output("hold_pulses", 32'(pulses), 32'd1);
      apply_stimulus(1'b0, 1'b0, 1'b1, 16'h0010, 32'hCAFEF00D, 0, lat, rdat, err, pulses);
      apply_stimulus(1'b0, 1'b0, 1'b1, 16'h004C, 32'h0BADC0DE, 0, lat, rdat, err, pulses);
      check_output("wr4c_err", 32'(err), 32'd0);
      apply_stimulus(1'b0, 1'b1, 1'b0, 16'h0010, 32'h0, 0, lat, rdat, err, pulses);
      check_output("b2b_rd10", rdat, 32'hCAFEF00D);
      apply_stimulus(1'b0, 1'b1, 1'b0, 16'h004C, 32'h0, 0, lat, rdat, err, pulses);
      check_output("b2b_rd4c", rdat, 32'h0BADC0DE);
      apply_stimulus(1'b0, 1'b1, 1'b0, 16'h0024, 32'h0, 0, lat, rdat, err, pulses);
      check_output("rd24_data", rdat, 32'h11112222);
      apply_stimulus(1'b0, 1'b1, 1'b0, 16'h0050, 32'h0, 0, lat, rdat, err, pulses);
      check_output("rd50_err", 32'(err), 32'd1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/slave_reg.md
# slave_reg

Bus responder for the master/responder register bus: accepts single read/write requests from `master_reg`, decodes them onto a parameterised register file, and returns a one-cycle `ready` with read data or an error flag. It sits at the far end of the bus, so the master's `DEADBEEF` write to `0x0010` lands in this block's register 0.

## Interface
- `ADDR_W`, 16, bus address width
- `DATA_W`, 32, bus data width
- `NUM_REGS`, 16, number of 32-bit registers (≥1)
- `BASE_ADDR`, 16'h0010, byte address of register 0; registers are word-spaced (stride 4)
- `WAIT_CYCLES`, 1, address-phase wait states before `ready` (≥1)

Ports:
- `clk`  in  1  bus clock; all state changes on the rising edge
- `reset_n`  in  1  reset, asynchronous, active-low
- `valid`  in  1  master request valid, held until `ready` is sampled
- `read`  in  1  read request
- `write`  in  1  write request
- `addr`  in  ADDR_W  byte address
- `write_data`  in  DATA_W  write payload
- `ready`  out  1  transfer complete, one-cycle pulse
- `read_data`  out  DATA_W  read result, valid only while `ready`=1
- `error`  out  1  decode/protocol error, valid only while `ready`=1

## Operation
- States: `RSP_IDLE`, `RSP_ADDR`, `RSP_DATA`, `RSP_DONE`.
- `RSP_IDLE`: when `valid`=1, latch `addr`, `read`, `write` and `write_data`, load the wait counter with WAIT_CYCLES−1, then go to `RSP_ADDR`.
- `RSP_ADDR`: decode the latched request and count down.
  - Counter = 0: go to `RSP_DATA`.
  - `valid`=0 at any edge: abort and go to `RSP_IDLE`. No write occurs and no `ready` is issued.
- Decode: the request is a hit when all of the following hold. Otherwise `error`=1.
  - `addr` ≥ BASE_ADDR and `addr` < BASE_ADDR + 4·NUM_REGS
  - `addr[1:0]` = 0
  - exactly one of `read`/`write` is set
- Register index = (`addr` − BASE_ADDR) >> 2. Compute it in ADDR_W bits; underflow is excluded by the range check.
- `RSP_DATA` (exactly one cycle):
  - `ready`=1.
  - Read hit: `read_data` = reg[index].
  - Write hit: reg[index] ← latched `write_data` at the exiting edge.
  - Error: `read_data`=0 and the write is dropped.
  - Next state is `RSP_DONE`.
- `RSP_DONE`: wait until `valid`=0, then go to `RSP_IDLE`. This prevents a held `valid` from re-triggering the same request.
- Registers are all read/write and reset to 0.

## Timing
- Reset state (`reset_n`=0): state = `RSP_IDLE`, `ready`=0, `read_data`=0, `error`=0, all registers = 0. Reset applies immediately, without waiting for a clock edge, including mid-transaction. An in-flight write is discarded.
- `ready`, `read_data` and `error` are registered outputs.
  - If the request is sampled at edge k, `ready` is high from edge k+1+WAIT_CYCLES for one cycle.
  - With the default WAIT_CYCLES=1, `ready` rises 2 edges after `valid` is first sampled.
- Outside `RSP_DATA`: `ready`=0, `error`=0, `read_data`=0.
- Written data is visible to a read sampled at any edge after the write's `ready` cycle.
- Back-to-back requests: minimum spacing is the `RSP_DONE` cycle plus one cycle of `valid` low. Throughput is one transfer per WAIT_CYCLES+3 cycles.
- The master must keep `addr`, `read`, `write` and `write_data` stable while `valid`=1. The block does not sample them after `RSP_IDLE`.

## Structure
- Shared package `bus_pkg` contains:
  - `rsp_state_t` enum. The `RSP_` prefix avoids clashing with the master's `IDLE`/`ADDR_PHASE`/`DATA_PHASE`.
  - ADDR_W/DATA_W defaults.
  - `BUS_BASE_ADDR`.
- Sub-module `slave_regfile` holds the NUM_REGS×DATA_W storage.
  - Ports: synchronous write enable/index/data, combinational read by index.
  - Reset: asynchronous, active-low, to 0.
- Top level holds the FSM, wait counter, decoder and output registers.

## Test plan
- Write `0x0010` ← 32'hDEADBEEF, then read `0x0010`: write `ready` 2 edges after `valid` with `error`=0; read returns 32'hDEADBEEF with `error`=0.
- Read `0x0100` (out of range) and `0x0012` (misaligned): each gives `ready`=1 with `error`=1 and `read_data`=0. A follow-up read of `0x0010` is unchanged.
- Request with `read`=`write`=1 at `0x0014`: `error`=1 and reg[1] keeps its previous value (0 after reset).
- Drop `valid` during `RSP_ADDR` (WAIT_CYCLES=3) on a write of 32'h12345678 to `0x0018`: no `ready` pulse, and a read of `0x0018` returns 0.
- Assert `reset_n`=0 mid-write and at the `ready` cycle: outputs go to 0 immediately and all registers read 0 afterwards.
- Hold `valid` high for 5 cycles after `ready`: exactly one `ready` pulse. Then two back-to-back writes to `0x0010`/`0x004C` (last register): both read back correctly.
